// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: state encoding,
// requester indices and default bus widths.
package ram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 7;

endpackage

// File: rtl/ram_arb2_ctrl_if.sv
// Requester-side access bus: request/command toward the controller,
// grant and read return back to the client.
interface ram_arb2_ctrl_if
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arb2_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt[gi] = req[gi] & (~req[1-gi] | (last_gnt != 1'(gi)));
    end
  endgenerate

endmodule

// File: rtl/ram_arb2_ctrl.sv
// Shares one single-port registered-read RAM between requesters A and B;
// optionally zero-fills the RAM after reset before arbitration starts.
module ram_arb2_ctrl
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_arb2_ctrl_if.slave        a,
  ram_arb2_ctrl_if.slave        b,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  init_done
);

  localparam state_t                ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg;
  logic [ADDR_WIDTH-1:0] hold_addr_reg;
  logic [DATA_WIDTH-1:0] hold_d_reg;
  logic                  last_gnt_reg;
  logic [1:0]            rd_owner_reg;
  logic                  init_done_reg;

  logic [1:0] req_vec;
  logic [1:0] we_vec;
  logic [1:0] arb_gnt;
  logic [1:0] gnt;
  logic [1:0] rd_next;

  assign req_vec = {b.req, a.req};
  assign we_vec  = {b.we, a.we};

  rr_arb2 u_arb (
    .req      (req_vec),
    .last_gnt (last_gnt_reg),
    .gnt      (arb_gnt)
  );

  // Requests are held off entirely while the RAM is being cleared.
  assign gnt     = (state_reg == ST_RUN) ? arb_gnt : 2'b00;
  assign rd_next = gnt & ~we_vec;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = hold_addr_reg;
    ram_d    = hold_d_reg;
    if (state_reg == ST_CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = clr_cnt_reg;
      ram_d    = '0;
    end else if (gnt[REQ_A]) begin
      ram_we   = a.we;
      ram_addr = a.addr;
      ram_d    = a.wdata;
    end else if (gnt[REQ_B]) begin
      ram_we   = b.we;
      ram_addr = b.addr;
      ram_d    = b.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_RESET;
      clr_cnt_reg   <= '0;
      hold_addr_reg <= '0;
      hold_d_reg    <= '0;
      last_gnt_reg  <= 1'(REQ_B);
      rd_owner_reg  <= 2'b00;
      init_done_reg <= ~CLEAR_ON_RESET;
    end else begin
      rd_owner_reg <= rd_next;
      if (state_reg == ST_CLEAR) begin
        clr_cnt_reg <= clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == CLR_LAST) begin
          state_reg     <= ST_RUN;
          init_done_reg <= 1'b1;
        end
      end else if (|gnt) begin
        last_gnt_reg  <= gnt[REQ_B];
        hold_addr_reg <= ram_addr;
        hold_d_reg    <= ram_d;
      end
    end
  end

  // Read data is steered only to the requester that owns the returning read.
  assign a.gnt     = gnt[REQ_A];
  assign b.gnt     = gnt[REQ_B];
  assign a.rvalid  = rd_owner_reg[REQ_A];
  assign b.rvalid  = rd_owner_reg[REQ_B];
  assign a.rdata   = rd_owner_reg[REQ_A] ? ram_q : '0;
  assign b.rdata   = rd_owner_reg[REQ_B] ? ram_q : '0;
  assign init_done = init_done_reg;

endmodule

// File: tb/tb_ram_arb2_ctrl.sv
// Bench for ram_arb2_ctrl: behavioural RAM, shadow memory and read-return
// scoreboard; a second instance covers the no-clear configuration.
module tb_ram_arb2_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arb2_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) a_if ();
  ram_arb2_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) b_if ();
  ram_arb2_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) a2_if ();
  ram_arb2_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) b2_if ();

  logic        ram_we, ram2_we;
  logic [6:0]  ram_addr, ram2_addr;
  logic [31:0] ram_d, ram2_d;
  logic [31:0] ram_q, ram2_q;
  logic        init_done, init2_done;
  logic [31:0] mem  [128];
  logic [31:0] mem2 [128];

  ram_arb2_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a_if),
    .b         (b_if),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_d     (ram_d),
    .ram_q     (ram_q),
    .init_done (init_done)
  );

  ram_arb2_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .CLEAR_ON_RESET(1'b0)) u_dut_nc (
    .clk       (clk),
    .rst_n     (rst2_n),
    .a         (a2_if),
    .b         (b2_if),
    .ram_we    (ram2_we),
    .ram_addr  (ram2_addr),
    .ram_d     (ram2_d),
    .ram_q     (ram2_q),
    .init_done (init2_done)
  );

  // Single-port RAMs, registered read, old data on read-during-write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
    if (ram2_we) mem2[ram2_addr] <= ram2_d;
    ram2_q <= mem2[ram2_addr];
  end

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        a_q[$];
  exp_t        b_q[$];
  logic [31:0] shadow [128];
  logic [6:0]  last_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_if.rvalid) begin
      if (a_q.size() == 0) chk("a_rvalid_unexpected", 64'(a_if.rvalid), 64'(0));
      else begin
        e = a_q.pop_front();
        chk("a_rv_cycle", 64'(cyc), 64'(e.cyc));
        chk("a_rdata", 64'(a_if.rdata), 64'(e.data));
        $display("rd  cyc=%0d A rdata=%08h", cyc, a_if.rdata);
      end
    end
    if (b_if.rvalid) begin
      if (b_q.size() == 0) chk("b_rvalid_unexpected", 64'(b_if.rvalid), 64'(0));
      else begin
        e = b_q.pop_front();
        chk("b_rv_cycle", 64'(cyc), 64'(e.cyc));
        chk("b_rdata", 64'(b_if.rdata), 64'(e.data));
        $display("rd  cyc=%0d B rdata=%08h", cyc, b_if.rdata);
      end
    end
  end

  // Called just after a posedge; returns just after the posedge n cycles later.
  task automatic clear_phase(input int n);
    int good = 0;
    int gnt_seen = 0;
    int done_seen = 0;
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 7'h01; a_if.wdata = '0;
    b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 7'h02; b_if.wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      #1;
      if (ram_we === 1'b1 && ram_addr === 7'(i) && ram_d === 32'h0) good++;
      if (a_if.gnt !== 1'b0 || b_if.gnt !== 1'b0) gnt_seen++;
      if (init_done !== 1'b0) done_seen++;
      @(posedge clk); #1;
    end
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    chk("clr_writes", 64'(good), 64'(n));
    chk("clr_gnt_seen", 64'(gnt_seen), 64'(0));
    chk("clr_done_early", 64'(done_seen), 64'(0));
    $display("clr cyc=%0d writes=%0d", cyc, good);
  endtask

  task automatic cyc_drive(input logic ar, input logic aw, input logic [6:0] aa, input logic [31:0] ad,
                           input logic br, input logic bw, input logic [6:0] ba, input logic [31:0] bd,
                           input logic ega, input logic egb);
    logic        x_we;
    logic [6:0]  x_addr;
    logic [31:0] x_data;
    exp_t        e;
    a_if.req = ar; a_if.we = aw; a_if.addr = aa; a_if.wdata = ad;
    b_if.req = br; b_if.we = bw; b_if.addr = ba; b_if.wdata = bd;
    #1;
    chk("a_gnt", 64'(a_if.gnt), 64'(ega));
    chk("b_gnt", 64'(b_if.gnt), 64'(egb));
    if (ega || egb) begin
      x_we   = ega ? aw : bw;
      x_addr = ega ? aa : ba;
      x_data = ega ? ad : bd;
      chk("ram_we", 64'(ram_we), 64'(x_we));
      chk("ram_addr", 64'(ram_addr), 64'(x_addr));
      if (x_we) begin
        chk("ram_d", 64'(ram_d), 64'(x_data));
        shadow[x_addr] = x_data;
      end else begin
        e.cyc  = cyc + 1;
        e.data = shadow[x_addr];
        if (ega) a_q.push_back(e);
        else b_q.push_back(e);
      end
      last_addr = x_addr;
    end else begin
      chk("idle_we", 64'(ram_we), 64'(0));
      chk("idle_addr", 64'(ram_addr), 64'(last_addr));
    end
    $display("txn cyc=%0d A:req=%b we=%b addr=%02h wd=%08h B:req=%b we=%b addr=%02h wd=%08h gnt=%b%b",
             cyc, ar, aw, aa, ad, br, bw, ba, bd, a_if.gnt, b_if.gnt);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) shadow[i] = 32'h0;
    a_if.req = 0; a_if.we = 0; a_if.addr = '0; a_if.wdata = '0;
    b_if.req = 0; b_if.we = 0; b_if.addr = '0; b_if.wdata = '0;
    a2_if.req = 0; a2_if.we = 0; a2_if.addr = '0; a2_if.wdata = '0;
    b2_if.req = 0; b2_if.we = 0; b2_if.addr = '0; b2_if.wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", 64'(init_done), 64'(0));
    chk("rst_a_rvalid", 64'(a_if.rvalid), 64'(0));
    chk("rst_b_rvalid", 64'(b_if.rvalid), 64'(0));
    rst_n = 1'b1;

    // Reset pulse partway through the clear restarts it from address 0.
    clear_phase(60);
    chk("clr_addr_60", 64'(ram_addr), 64'(60));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_init_done", 64'(init_done), 64'(0));
    clear_phase(128);
    #1;
    chk("init_done_rise", 64'(init_done), 64'(1));

    cyc_drive(1, 0, 7'h55, 32'h0, 0, 0, 7'h00, 32'h0, 1, 0);
    cyc_drive(1, 1, 7'h10, 32'hDEADBEEF, 0, 0, 7'h00, 32'h0, 1, 0);
    cyc_drive(1, 0, 7'h10, 32'h0, 0, 0, 7'h00, 32'h0, 1, 0);
    cyc_drive(0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0, 0, 0);
    // Read then write of 0x20: the read sees the old contents.
    cyc_drive(0, 0, 7'h00, 32'h0, 1, 0, 7'h20, 32'h0, 0, 1);
    cyc_drive(1, 1, 7'h20, 32'h12345678, 0, 0, 7'h00, 32'h0, 1, 0);
    cyc_drive(0, 0, 7'h00, 32'h0, 1, 0, 7'h20, 32'h0, 0, 1);
    cyc_drive(1, 1, 7'h01, 32'h11111111, 0, 0, 7'h00, 32'h0, 1, 0);
    cyc_drive(0, 0, 7'h00, 32'h0, 1, 1, 7'h02, 32'h22222222, 0, 1);
    for (int i = 0; i < 6; i++)
      cyc_drive(1, 0, 7'h01, 32'h0, 1, 0, 7'h02, 32'h0, (i % 2) == 0, (i % 2) == 1);
    // Write and read contend; the loser re-tries next cycle and sees new data.
    cyc_drive(1, 1, 7'h03, 32'h33333333, 1, 0, 7'h03, 32'h0, 1, 0);
    cyc_drive(0, 0, 7'h00, 32'h0, 1, 0, 7'h03, 32'h0, 0, 1);
    cyc_drive(0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0, 0, 0);
    cyc_drive(0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0, 0, 0);
    chk("a_q_left", 64'(a_q.size()), 64'(0));
    chk("b_q_left", 64'(b_q.size()), 64'(0));

    // Instance without clear: usable on the first cycle out of reset.
    rst2_n = 1'b1;
    #1;
    chk("nc_init_done", 64'(init2_done), 64'(1));
    a2_if.req = 1; a2_if.we = 1; a2_if.addr = 7'h05; a2_if.wdata = 32'hCAFEF00D;
    #1;
    chk("nc_a_gnt", 64'(a2_if.gnt), 64'(1));
    chk("nc_ram_we", 64'(ram2_we), 64'(1));
    chk("nc_ram_addr", 64'(ram2_addr), 64'(5));
    $display("txn nc cyc=%0d A write 05=cafef00d gnt=%b", cyc, a2_if.gnt);
    @(posedge clk); #1;
    a2_if.we = 0;
    #1;
    chk("nc_a_gnt_rd", 64'(a2_if.gnt), 64'(1));
    @(posedge clk); #1;
    a2_if.req = 0;
    #1;
    chk("nc_a_rvalid", 64'(a2_if.rvalid), 64'(1));
    chk("nc_a_rdata", 64'(a2_if.rdata), 64'(32'hCAFEF00D));
    $display("txn nc cyc=%0d A read 05 rdata=%08h", cyc, a2_if.rdata);
    @(posedge clk); #1;
    chk("nc_a_rvalid_drop", 64'(a2_if.rvalid), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
